addrns_pipe: RTL and testbench

ADDRNS_PIPE -- requirements
Module: addrns_pipe

---
 rtl/addrns_pipe.sv | 93 +++++++++
 tb/tb_addrns_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/addrns_pipe.sv
// addrns_pipe: elastic segmented-carry signed add/sub with saturation, overflow and mod-3 residue check
module addrns_pipe #(
  parameter int W = 8,
  parameter int STAGES = 2,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            sub,
  input  logic            fi_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W:0]      sum,
  output logic [W-1:0]    sat,
  output logic            ovf,
  output logic            res_err,
  output logic [CNTW-1:0] err_cnt
);
  localparam int SEG = (W + STAGES - 1) / STAGES;
  localparam int L = STAGES - 1;
  function automatic logic [1:0] m3(input logic signed [W:0] x);
    logic signed [W+1:0] t;
    t = (W + 2)'(x) % (W + 2)'(3);
    return t[W+1] ? 2'(t + (W + 2)'(3)) : t[1:0];
  endfunction
  logic [W:0] ax0, bx0, sx;
  logic [1:0] ra, rb, r0;
  logic [2:0] rs;
  assign ax0 = {a[W-1], a};
  assign sx = {b[W-1], b};
  assign bx0 = sx ^ {(W + 1){sub}};
  assign ra = m3(ax0);
  assign rb = m3(sx);
  assign rs = sub ? {1'b0, ra} + 3'd3 - {1'b0, rb} : {1'b0, ra} + {1'b0, rb};
  assign r0 = rs >= 3'd3 ? 2'(rs - 3'd3) : rs[1:0];
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : stg
      localparam int LO = k * SEG < W ? k * SEG : W;
      localparam int HI = k == L ? W + 1 : ((k + 1) * SEG < W ? (k + 1) * SEG : W);
      localparam logic [W:0] M = ((W + 1)'(1) << HI) - ((W + 1)'(1) << LO);
      logic [W:0] ax_i, bx_i, s_i, t, ax_q, bx_q, s_q;
      logic [1:0] r_i, r_q;
      logic f_i, v_i, f_q, v_q, adv, ld;
      if (k == 0) begin : src
        assign ax_i = ax0;
        assign bx_i = bx0;
        assign s_i = (W + 1)'(sub);
        assign r_i = r0;
        assign f_i = fi_en;
        assign v_i = in_valid && in_ready;
      end else begin : src
        assign ax_i = stg[k-1].ax_q;
        assign bx_i = stg[k-1].bx_q;
        assign s_i = stg[k-1].s_q;
        assign r_i = stg[k-1].r_q;
        assign f_i = stg[k-1].f_q;
        assign v_i = stg[k-1].v_q;
      end
      if (k == L) begin : nx
        assign adv = v_q && out_ready;
      end else begin : nx
        assign adv = v_q && stg[k+1].ld;
      end
      assign ld = !v_q || adv;
      assign t = (s_i + (ax_i & M) + (bx_i & M)) ^ (W + 1)'(k == L && f_i);
      always_ff @(posedge clk)
        if (rst) v_q <= 1'b0;
        else if (ld) v_q <= v_i;
      always_ff @(posedge clk)
        if (ld && v_i) begin
          ax_q <= ax_i;
          bx_q <= bx_i;
          s_q <= t;
          r_q <= r_i;
          f_q <= f_i;
        end
    end
  endgenerate
  assign in_ready = !rst && stg[0].ld;
  assign out_valid = stg[L].v_q;
  assign sum = stg[L].s_q;
  assign ovf = sum[W] ^ sum[W-1];
  assign sat = ovf ? {sum[W], {(W - 1){!sum[W]}}} : sum[W-1:0];
  assign res_err = out_valid && (m3(sum) != stg[L].r_q);
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (out_valid && out_ready && res_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
endmodule

// File: tb/tb_addrns_pipe.sv
// tb_addrns_pipe: scoreboard bench for addrns_pipe with directed and randomized beats
module tb_addrns_pipe;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, sub = 0, fi_en = 0, out_ready = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid, ovf, res_err;
  logic [W-1:0] sat;
  logic [W:0] sum;
  logic [7:0] err_cnt;
  int tests = 0, fails = 0, cyc = 0, exp_cnt = 0;
  bit chk_lat = 0, rnd = 0;
  typedef struct {
    logic [W:0] sum;
    logic [W-1:0] sat;
    logic ovf, err;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic hold = 0;
  logic [W+W+2:0] hv;
  addrns_pipe #(.W(W), .STAGES(2), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .fi_en(fi_en), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sat(sat), .ovf(ovf), .res_err(res_err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic exp_t model(int ai, int bi, bit s, bit f, int c);
    exp_t r;
    int v;
    v = (s ? ai - bi : ai + bi) ^ int'(f);
    r.sum = (W + 1)'(v);
    r.ovf = v > 127 || v < -128;
    r.sat = W'(v > 127 ? 127 : v < -128 ? -128 : v);
    r.err = f;
    r.cyc = c;
    return r;
  endfunction
  always @(negedge clk)
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(model(int'($signed(a)), int'($signed(b)), sub, fi_en, cyc));
  always @(negedge clk)
    if (rst) begin
      exp_cnt = 0;
      hold = 0;
    end else begin
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {sum, sat, ovf, res_err}, hv);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat: got sum %0h expected no beat", sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.sum);
          chk("sat", sat, e.sat);
          chk("ovf", ovf, e.ovf);
          chk("res_err", res_err, e.err);
          chk("err_cnt", err_cnt, exp_cnt);
          if (chk_lat) chk("latency", cyc - e.cyc, 2);
          else chk("latency_min", cyc - e.cyc >= 2, 1);
          if (e.err && exp_cnt < 255) exp_cnt++;
        end
      end
      hold = out_valid && !out_ready;
      hv = {sum, sat, ovf, res_err};
    end
  initial forever begin
    @(posedge clk);
    if (rnd) begin
      #1 out_ready = $urandom_range(0, 3) != 0;
    end
  end
  task automatic send(int ai, int bi, bit s, bit f);
    bit acc;
    int n = 0;
    in_valid = 1;
    a = W'(ai);
    b = W'(bi);
    sub = s;
    fi_en = f;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1 n++;
    end while (!acc && n < 200);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    in_valid = 0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    fi_en = 1'($urandom);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", out_valid, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_res_err", res_err, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1;
    chk_lat = 1;
    send(127, 1, 0, 0);
    send(-128, 1, 1, 0);
    send(-5, 3, 0, 0);
    send(-128, -128, 0, 0);
    send(127, -128, 1, 0);
    drain();
    chk_lat = 0;
    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(i * 30 - 50, 17 + i, i[0], 0);
      end
    join_none
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_queued", q.size(), 2);
    @(posedge clk);
    #1 out_ready = 1;
    wait fork;
    drain();
    chk_lat = 1;
    send(10, 20, 0, 1);
    send(10, 20, 0, 0);
    drain();
    chk("fi_err_cnt", err_cnt, 1);
    chk_lat = 0;
    out_ready = 0;
    send(1, 2, 0, 0);
    send(3, 4, 1, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_err_cnt", err_cnt, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1 chk_lat = 1;
    send(-100, 50, 1, 0);
    drain();
    chk_lat = 0;
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(int'($signed(W'($urandom))), int'($signed(W'($urandom))), 1'($urandom), 0);
    end
    rnd = 0;
    @(posedge clk);
    #2 out_ready = 1;
    drain();
    chk("final_err_cnt", err_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
